// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_port_arbiter
// Brief   : Round-robin arbiter/sequencer for the single data-cache port.
// Revision: 1.0
// ============================================================================
module dmem_port_arbiter #(
    parameter int ABITS   = 64,
    parameter int MEMOP_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             i_req_valid,
    output logic [1:0]             o_req_ready,
    input  logic [2*MEMOP_W-1:0]   i_req_type,
    input  logic [2*ABITS-1:0]     i_req_addr,
    input  logic [127:0]           i_req_wdata,
    input  logic [15:0]            i_req_wstrb,
    input  logic [3:0]             i_req_size,
    output logic [1:0]             o_resp_valid,
    input  logic [1:0]             i_resp_ready,
    output logic [ABITS-1:0]       o_resp_data,
    output logic                   o_resp_load_fault,
    output logic                   o_resp_store_fault,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic [MEMOP_W-1:0]     o_mem_req_type,
    output logic [ABITS-1:0]       o_mem_req_addr,
    output logic [63:0]            o_mem_req_wdata,
    output logic [7:0]             o_mem_req_wstrb,
    output logic [1:0]             o_mem_req_size,
    input  logic                   i_mem_resp_valid,
    output logic                   o_mem_resp_ready,
    input  logic [ABITS-1:0]       i_mem_resp_data,
    input  logic                   i_mem_resp_load_fault,
    input  logic                   i_mem_resp_store_fault,
    output logic                   o_owner,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_ACCEPT = 2'd1,
        ST_WAIT_RESP   = 2'd2,
        ST_HOLD        = 2'd3
    } state_t;

    state_t               state_q;
    logic                 owner_q;
    logic                 last_grant_q;
    logic [MEMOP_W-1:0]   type_q;
    logic [ABITS-1:0]     addr_q;
    logic [63:0]          wdata_q;
    logic [7:0]           wstrb_q;
    logic [1:0]           size_q;
    logic [ABITS-1:0]     hold_rdata_q;
    logic                 hold_load_fault_q;
    logic                 hold_store_fault_q;

    logic                 winner_d;
    logic                 grant_d;
    logic [MEMOP_W-1:0]   sel_type_d;
    logic [ABITS-1:0]     sel_addr_d;
    logic [63:0]          sel_wdata_d;
    logic [7:0]           sel_wstrb_d;
    logic [1:0]           sel_size_d;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        winner_d    = (&i_req_valid) ? ~last_grant_q : i_req_valid[1];
        grant_d     = (state_q == ST_IDLE) && (|i_req_valid);
        sel_type_d  = winner_d ? i_req_type[2*MEMOP_W-1:MEMOP_W] : i_req_type[MEMOP_W-1:0];
        sel_addr_d  = winner_d ? i_req_addr[2*ABITS-1:ABITS]     : i_req_addr[ABITS-1:0];
        sel_wdata_d = winner_d ? i_req_wdata[127:64]             : i_req_wdata[63:0];
        sel_wstrb_d = winner_d ? i_req_wstrb[15:8]               : i_req_wstrb[7:0];
        sel_size_d  = winner_d ? i_req_size[3:2]                 : i_req_size[1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q            <= ST_IDLE;
            owner_q            <= 1'b0;
            last_grant_q       <= 1'b1;
            type_q             <= '0;
            addr_q             <= '0;
            wdata_q            <= '0;
            wstrb_q            <= '0;
            size_q             <= '0;
            hold_rdata_q       <= '0;
            hold_load_fault_q  <= 1'b0;
            hold_store_fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        type_q       <= sel_type_d;
                        addr_q       <= sel_addr_d;
                        wdata_q      <= sel_wdata_d;
                        wstrb_q      <= sel_wstrb_d;
                        size_q       <= sel_size_d;
                        owner_q      <= winner_d;
                        last_grant_q <= winner_d;
                        state_q      <= ST_WAIT_ACCEPT;
                    end
                end
                ST_WAIT_ACCEPT: begin
                    if (i_mem_req_ready) begin
                        state_q <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (i_mem_resp_valid) begin
                        hold_rdata_q       <= i_mem_resp_data;
                        hold_load_fault_q  <= i_mem_resp_load_fault;
                        hold_store_fault_q <= i_mem_resp_store_fault;
                        state_q            <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (i_resp_ready[owner_q]) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_req_ready = 2'b00;
        if (grant_d) begin
            o_req_ready = winner_d ? 2'b10 : 2'b01;
        end
        o_resp_valid = 2'b00;
        if (state_q == ST_HOLD) begin
            o_resp_valid = owner_q ? 2'b10 : 2'b01;
        end
    end

    assign o_resp_data        = hold_rdata_q;
    assign o_resp_load_fault  = hold_load_fault_q;
    assign o_resp_store_fault = hold_store_fault_q;
    assign o_mem_req_valid    = (state_q == ST_WAIT_ACCEPT);
    assign o_mem_req_type     = type_q;
    assign o_mem_req_addr     = addr_q;
    assign o_mem_req_wdata    = wdata_q;
    assign o_mem_req_wstrb    = wstrb_q;
    assign o_mem_req_size     = size_q;
    assign o_mem_resp_ready   = (state_q == ST_WAIT_RESP);
    assign o_owner            = owner_q;
    assign o_busy             = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_port_arbiter
// Brief   : Directed self-checking bench for dmem_port_arbiter.
// Revision: 1.0
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int ABITS   = 64;
    localparam int MEMOP_W = 4;

    logic                 clk;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [2*MEMOP_W-1:0] req_type;
    logic [2*ABITS-1:0]   req_addr;
    logic [127:0]         req_wdata;
    logic [15:0]          req_wstrb;
    logic [3:0]           req_size;
    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready;
    logic [ABITS-1:0]     resp_data;
    logic                 resp_load_fault;
    logic                 resp_store_fault;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [MEMOP_W-1:0]   mem_req_type;
    logic [ABITS-1:0]     mem_req_addr;
    logic [63:0]          mem_req_wdata;
    logic [7:0]           mem_req_wstrb;
    logic [1:0]           mem_req_size;
    logic                 mem_resp_valid;
    logic                 mem_resp_ready;
    logic [ABITS-1:0]     mem_resp_data;
    logic                 mem_resp_load_fault;
    logic                 mem_resp_store_fault;
    logic                 owner;
    logic                 busy;

    int checks;
    int failures;

    dmem_port_arbiter #(.ABITS(ABITS), .MEMOP_W(MEMOP_W)) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_req_valid            (req_valid),
        .o_req_ready            (req_ready),
        .i_req_type             (req_type),
        .i_req_addr             (req_addr),
        .i_req_wdata            (req_wdata),
        .i_req_wstrb            (req_wstrb),
        .i_req_size             (req_size),
        .o_resp_valid           (resp_valid),
        .i_resp_ready           (resp_ready),
        .o_resp_data            (resp_data),
        .o_resp_load_fault      (resp_load_fault),
        .o_resp_store_fault     (resp_store_fault),
        .o_mem_req_valid        (mem_req_valid),
        .i_mem_req_ready        (mem_req_ready),
        .o_mem_req_type         (mem_req_type),
        .o_mem_req_addr         (mem_req_addr),
        .o_mem_req_wdata        (mem_req_wdata),
        .o_mem_req_wstrb        (mem_req_wstrb),
        .o_mem_req_size         (mem_req_size),
        .i_mem_resp_valid       (mem_resp_valid),
        .o_mem_resp_ready       (mem_resp_ready),
        .i_mem_resp_data        (mem_resp_data),
        .i_mem_resp_load_fault  (mem_resp_load_fault),
        .i_mem_resp_store_fault (mem_resp_store_fault),
        .o_owner                (owner),
        .o_busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid got=%h exp=0", mem_req_valid); end
        checks++; if (mem_resp_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_resp_ready got=%h exp=0", mem_resp_ready); end
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%h exp=0", resp_valid); end
        checks++; if (resp_data !== 64'h0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
        checks++; if ({resp_load_fault, resp_store_fault} !== 2'b00) begin failures++; $display("FAIL reset_faults got=%b exp=00", {resp_load_fault, resp_store_fault}); end
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%h exp=0", owner); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        tick;
        tick;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single;
        req_valid        = 2'b01;
        req_type[3:0]    = 4'd0;
        req_addr[63:0]   = 64'h0000_0000_8000_1000;
        req_size[1:0]    = 2'd3;
        mem_req_ready    = 1'b1;
        mem_resp_valid   = 1'b1;
        mem_resp_data    = 64'h1122_3344_5566_7788;
        resp_ready       = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", req_ready); end
        tick;
        req_valid = 2'b00;
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL single_mem_req_valid got=%h exp=1", mem_req_valid); end
        checks++; if (mem_req_addr !== 64'h8000_1000) begin failures++; $display("FAIL single_addr got=%h exp=80001000", mem_req_addr); end
        checks++; if (mem_req_size !== 2'd3) begin failures++; $display("FAIL single_size got=%h exp=3", mem_req_size); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%h exp=1", busy); end
        tick;
        checks++; if (mem_resp_ready !== 1'b1) begin failures++; $display("FAIL single_mem_resp_ready got=%h exp=1", mem_resp_ready); end
        tick;
        checks++; if (resp_valid !== 2'b01) begin failures++; $display("FAIL single_resp_valid got=%b exp=01", resp_valid); end
        checks++; if (resp_data !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL single_resp_data got=%h exp=1122334455667788", resp_data); end
        tick;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%h exp=0", busy); end
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL single_resp_valid_fall got=%b exp=00", resp_valid); end
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_contention;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req_addr       = {64'h2000, 64'h1000};
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        resp_ready     = 2'b11;
        req_valid      = 2'b11;
        #1;
        for (int t = 0; t < 4; t++) begin
            logic       exp_owner;
            logic [1:0] exp_ready;
            exp_owner = t[0];
            exp_ready = exp_owner ? 2'b10 : 2'b01;
            checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL contention_ready[%0d] got=%b exp=%b", t, req_ready, exp_ready); end
            tick;
            checks++; if (owner !== exp_owner) begin failures++; $display("FAIL contention_owner[%0d] got=%h exp=%h", t, owner, exp_owner); end
            checks++; if (mem_req_addr !== (exp_owner ? 64'h2000 : 64'h1000)) begin failures++; $display("FAIL contention_addr[%0d] got=%h", t, mem_req_addr); end
            for (int c = 0; c < 3; c++) begin
                checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL contention_busy_ready[%0d] got=%b exp=00", t, req_ready); end
                tick;
            end
        end
        req_valid      = 2'b00;
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        req_valid         = 2'b10;
        req_addr[127:64]  = 64'hDEAD_0000;
        mem_req_ready     = 1'b0;
        mem_resp_valid    = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_grant got=%b exp=10", req_ready); end
        tick;
        req_addr[127:64] = 64'hBEEF_0000;
        for (int c = 0; c < 5; c++) begin
            checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL bp_mem_req_valid[%0d] got=%h exp=1", c, mem_req_valid); end
            checks++; if (mem_req_addr !== 64'hDEAD_0000) begin failures++; $display("FAIL bp_addr[%0d] got=%h exp=dead0000", c, mem_req_addr); end
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_no_grant[%0d] got=%b exp=00", c, req_ready); end
            tick;
        end
        mem_req_ready  = 1'b1;
        tick;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hCAFE;
        tick;
        resp_ready     = 2'b01;
        mem_resp_data  = 64'h1234;
        for (int c = 0; c < 3; c++) begin
            checks++; if (resp_valid !== 2'b10) begin failures++; $display("FAIL bp_resp_valid[%0d] got=%b exp=10", c, resp_valid); end
            checks++; if (resp_data !== 64'hCAFE) begin failures++; $display("FAIL bp_resp_data[%0d] got=%h exp=cafe", c, resp_data); end
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_hold_no_grant[%0d] got=%b exp=00", c, req_ready); end
            tick;
        end
        resp_ready = 2'b11;
        tick;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_release got=%h exp=0", busy); end
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_regrant got=%b exp=10", req_ready); end
        req_valid      = 2'b00;
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_faults;
        req_valid            = 2'b10;
        req_type[7:4]        = 4'd1;
        req_wstrb[15:8]      = 8'h0F;
        req_wdata[127:64]    = 64'hAAAA_5555_0000_FFFF;
        req_addr[127:64]     = 64'h2040;
        req_size[3:2]        = 2'd2;
        mem_resp_valid       = 1'b1;
        mem_resp_data        = 64'h5555;
        mem_resp_store_fault = 1'b1;
        mem_resp_load_fault  = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL fault_grant got=%b exp=10", req_ready); end
        tick;
        req_valid = 2'b00;
        checks++; if (mem_req_type !== 4'd1) begin failures++; $display("FAIL fault_type got=%h exp=1", mem_req_type); end
        checks++; if (mem_req_wstrb !== 8'h0F) begin failures++; $display("FAIL fault_wstrb got=%h exp=0f", mem_req_wstrb); end
        checks++; if (mem_req_wdata !== 64'hAAAA_5555_0000_FFFF) begin failures++; $display("FAIL fault_wdata got=%h", mem_req_wdata); end
        checks++; if (mem_req_size !== 2'd2) begin failures++; $display("FAIL fault_size got=%h exp=2", mem_req_size); end
        tick;
        tick;
        checks++; if (resp_valid !== 2'b10) begin failures++; $display("FAIL fault_resp_valid got=%b exp=10", resp_valid); end
        checks++; if (resp_store_fault !== 1'b1) begin failures++; $display("FAIL fault_store got=%h exp=1", resp_store_fault); end
        checks++; if (resp_load_fault !== 1'b0) begin failures++; $display("FAIL fault_load got=%h exp=0", resp_load_fault); end
        tick;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fault_done got=%h exp=0", busy); end
        mem_resp_valid       = 1'b0;
        mem_resp_store_fault = 1'b0;
    endtask

    task automatic test_early_response;
        req_valid       = 2'b01;
        req_addr[63:0]  = 64'h3000;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b1;
        mem_resp_data   = 64'h0A0A;
        #1;
        tick;
        req_valid = 2'b00;
        for (int c = 0; c < 2; c++) begin
            checks++; if (mem_resp_ready !== 1'b0) begin failures++; $display("FAIL early_resp_ready[%0d] got=%h exp=0", c, mem_resp_ready); end
            checks++; if (resp_data !== 64'h5555) begin failures++; $display("FAIL early_no_capture[%0d] got=%h exp=5555", c, resp_data); end
            tick;
        end
        mem_req_ready = 1'b1;
        tick;
        checks++; if (mem_resp_ready !== 1'b1) begin failures++; $display("FAIL early_wait_resp got=%h exp=1", mem_resp_ready); end
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL early_resp_valid got=%b exp=00", resp_valid); end
        tick;
        checks++; if (resp_valid !== 2'b01) begin failures++; $display("FAIL early_hold got=%b exp=01", resp_valid); end
        checks++; if (resp_data !== 64'h0A0A) begin failures++; $display("FAIL early_capture got=%h exp=0a0a", resp_data); end
        checks++; if (resp_store_fault !== 1'b0) begin failures++; $display("FAIL early_store_fault got=%h exp=0", resp_store_fault); end
        tick;
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_mid_reset;
        req_valid      = 2'b01;
        req_addr[63:0] = 64'h4000;
        mem_resp_valid = 1'b0;
        #1;
        tick;
        req_valid = 2'b00;
        tick;
        checks++; if (mem_resp_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_wait got=%h exp=1", mem_resp_ready); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%h exp=0", busy); end
        checks++; if (mem_resp_ready !== 1'b0) begin failures++; $display("FAIL midrst_mem_resp_ready got=%h exp=0", mem_resp_ready); end
        checks++; if (mem_req_addr !== 64'h0) begin failures++; $display("FAIL midrst_addr got=%h exp=0", mem_req_addr); end
        checks++; if (resp_data !== 64'h0) begin failures++; $display("FAIL midrst_resp_data got=%h exp=0", resp_data); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL midrst_mem_req_valid got=%h exp=0", mem_req_valid); end
        tick;
        rst       = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midrst_next_grant got=%b exp=01", req_ready); end
        tick;
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL midrst_owner got=%h exp=0", owner); end
        req_valid = 2'b00;
    endtask

    initial begin
        checks               = 0;
        failures             = 0;
        req_valid            = '0;
        req_type             = '0;
        req_addr             = '0;
        req_wdata            = '0;
        req_wstrb            = '0;
        req_size             = '0;
        resp_ready           = '0;
        mem_req_ready        = 1'b0;
        mem_resp_valid       = 1'b0;
        mem_resp_data        = '0;
        mem_resp_load_fault  = 1'b0;
        mem_resp_store_fault = 1'b0;
        test_reset;
        test_single;
        test_contention;
        test_backpressure;
        test_faults;
        test_early_response;
        test_mid_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter and sequencer for the single data-cache request/response port. Requester 0 is the memory-access stage; requester 1 is the page-table walker / debug access path. The block grants one requester at a time in round-robin order and registers the granted request. It keeps exactly one transaction outstanding on the data-cache port and routes the response back to the owner through a registered hold stage.

## Interface
- ABITS, 64, address and data width (RISCV_ARCH)
- MEMOP_W, 4, memop type width (MemopType_Total)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_req_valid  in  2  per-requester request valid, bit n = requester n
- o_req_ready  out  2  per-requester accept strobe
- i_req_type  in  2*MEMOP_W  packed memop type, slice n = requester n
- i_req_addr  in  2*ABITS  packed request address
- i_req_wdata  in  128  packed write data, 64 per requester
- i_req_wstrb  in  16  packed byte strobes, 8 per requester
- i_req_size  in  4  packed access size, 2 per requester
- o_resp_valid  out  2  per-requester response valid
- i_resp_ready  in  2  per-requester response accept
- o_resp_data  out  ABITS  response data, valid for the owner only
- o_resp_load_fault  out  1  load access fault for the owner
- o_resp_store_fault  out  1  store access fault for the owner
- o_mem_req_valid  out  1  data-cache request valid
- i_mem_req_ready  in  1  data-cache request accept
- o_mem_req_type  out  MEMOP_W  registered type
- o_mem_req_addr  out  ABITS  registered address
- o_mem_req_wdata  out  64  registered write data
- o_mem_req_wstrb  out  8  registered strobes
- o_mem_req_size  out  2  registered size
- i_mem_resp_valid  in  1  data-cache response valid
- o_mem_resp_ready  out  1  data-cache response accept
- i_mem_resp_data  in  ABITS  response data
- i_mem_resp_load_fault  in  1  load fault
- i_mem_resp_store_fault  in  1  store fault
- o_owner  out  1  index of the current or last owner
- o_busy  out  1  high when state is not Idle

## Operation
- State machine: Idle, WaitReqAccept, WaitResponse, Hold. Reset state is Idle.
- Registers:
  - state; owner; last_grant (reset 1, so requester 0 wins first)
  - request fields type/addr/wdata/wstrb/size, all reset 0
  - hold_rdata, hold_load_fault, hold_store_fault, all reset 0
- Idle, arbitration (combinational):
  - only one requester valid: it wins.
  - both valid: the requester ≠ last_grant wins.
  - o_req_ready[winner]=1 in Idle only; every other o_req_ready bit is 0.
- Idle, on grant:
  - capture the winner's request slice; owner←winner; last_grant←winner; state←WaitReqAccept.
- WaitReqAccept:
  - o_mem_req_valid=1; request outputs driven from registers.
  - on i_mem_req_ready, state←WaitResponse.
- WaitResponse:
  - o_mem_resp_ready=1.
  - on i_mem_resp_valid, capture data and both faults into the hold registers; state←Hold.
- Hold:
  - o_resp_valid[owner]=1; o_resp_data and fault outputs driven from the hold registers.
  - on i_resp_ready[owner], state←Idle.
  - i_resp_ready of the non-owner is ignored.
- o_mem_resp_ready=0 outside WaitResponse. A response presented early is simply not accepted; the cache holds it.
- New requests are never accepted outside Idle. At most one outstanding transaction.
- Requests are forwarded unmodified; the block performs no width or alignment arithmetic.

## Timing
- Reset values of outputs:
  - o_req_ready=0 whenever neither requester is valid.
  - o_mem_req_valid=0, o_mem_resp_ready=0, o_resp_valid=0.
  - o_resp_data=0, both fault outputs=0.
  - o_owner=0, o_busy=0.
- Minimum transaction, with i_mem_req_ready, i_mem_resp_valid and i_resp_ready all held high:
  - cycle N: grant.
  - N+1: o_mem_req_valid.
  - N+2: o_mem_resp_ready, response captured.
  - N+3: o_resp_valid.
  - N+4: Idle, next grant possible. Back-to-back throughput is one transaction per 4 cycles.
- Request and response handshakes complete on the cycle where valid & ready are both high.
- Request registers are stable from WaitReqAccept until the next grant.
- Asserting i_rst in any state returns the block to Idle and clears all registers asynchronously. Any outstanding transaction is dropped; the data cache must be reset together with this block.
- A requester that drops i_req_valid before it is granted is not remembered.

## Test plan
- Single request:
  - stimulus: requester 0 read, addr 0x80001000, size 3; mem accepts immediately; returns data 0x1122334455667788.
  - required: o_resp_valid=2'b01 at grant+3 with that data; o_busy falls at grant+4.
- Contention:
  - stimulus: both requesters hold valid across 4 transactions from reset.
  - required: grant order 0,1,0,1; o_req_ready is never 2'b11.
- Backpressure:
  - stimulus: i_mem_req_ready low for 5 cycles; i_resp_ready[1] low for 3 cycles in Hold.
  - required: o_mem_req_addr and o_resp_data stay constant; no second grant.
- Faults:
  - stimulus: requester 1 store, wstrb 0x0F; mem returns store_fault=1.
  - required: o_resp_store_fault=1 and o_resp_valid=2'b10; o_resp_load_fault=0.
- Early response:
  - stimulus: i_mem_resp_valid high while in WaitReqAccept.
  - required: o_mem_resp_ready=0 until WaitResponse; the response is captured only then.
- Mid-operation reset:
  - stimulus: i_rst pulsed in WaitResponse.
  - required: all outputs return to reset values immediately; the next grant goes to requester 0.
